// File: rtl/regfile_mp_pkg.sv
// Shared constants and types for the multi-port register file.
// Polarity constants, the zero word and default widths live here only.
package regfile_mp_pkg;

    localparam logic RST_ACTIVE = 1'b1;
    localparam logic EN_ACTIVE  = 1'b1;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    localparam logic [DEFAULT_DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        StInit,
        StReady
    } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One read port of regfile_mp: write-to-read bypass mux and busy qualification.
// Highest-index matching write port wins the bypass.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     ready,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [NUM_WR-1:0]        wr_act,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0]        arr_data,
    input  logic                     arr_busy,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);

    localparam logic [DATA_W-1:0] ZERO = DATA_W'(ZERO_WORD);

    logic              hit;
    logic [DATA_W-1:0] fwd_data;

    // wr_act is already qualified by READY and a non-zero address.
    always_comb begin
        hit      = 1'b0;
        fwd_data = ZERO;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_act[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr)) begin
                hit      = 1'b1;
                fwd_data = wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_data = ZERO;
        rd_busy = 1'b0;
        if (ready && (rd_en == EN_ACTIVE) && (rd_addr != '0)) begin
            rd_data = hit ? fwd_data : arr_data;
            rd_busy = arr_busy & ~hit;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and post-reset clear sweep.
// Holds the array, write priority, busy vector and the INIT/READY FSM.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int unsigned       DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ZERO  = DATA_W'(ZERO_WORD);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready;
    logic [NUM_WR-1:0] wr_act;
    logic              alloc_act;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    // Gating with rst keeps outputs quiet from time zero, before the first edge.
    assign ready     = (state_q == StReady) && (rst != RST_ACTIVE);
    assign init_done = ready;
    assign alloc_act = ready && (alloc_en == EN_ACTIVE) && (alloc_addr != '0);

    always_comb begin
        wr_act = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            wr_act[w] = ready && (wr_en[w] == EN_ACTIVE) &&
                        (wr_addr[w*ADDR_W +: ADDR_W] != '0);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StInit: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST) begin
                    state_d = StReady;
                end
            end
            StReady: state_d = StReady;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q <= StInit;
            ptr_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Register 0 is never written; ports force its read value to zero.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            regs[ptr_q] <= ZERO;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_act[w]) begin
                    regs[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Writes clear first so a same-cycle alloc to the same register wins.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_act[w]) begin
                busy_d[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (alloc_act) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            busy_q <= '0;
        end else if (ready) begin
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd_port (
            .ready    (ready),
            .rd_en    (rd_en[k]),
            .rd_addr  (addr),
            .wr_act   (wr_act),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .arr_data (regs[addr]),
            .arr_busy (busy_q[addr]),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule
